ex_flush_gen: RTL
=================

// Module: ex_flush_gen
// PURPOSE
//  Execute-stage flush source. Turns resolved control-flow events (jal, jalr, taken branch, trap)
//  into the 2-bit flush code and redirect PC consumed by the flush-stall controller and fetch.
//  flush is presented for exactly one cycle, the cycle where cycle_cnt == SAMPLE_CNT.
//  Events from squashed (shadow) instructions are dropped until the flush has drained.
// PARAMETERS
//  ADDR_W      32     width of PC / target / trap vector
//  SAMPLE_CNT  4      cycle_cnt value at which the consumer samples flush
// PORTS
//  hclk         in   1       clock
//  hrstn        in   1       synchronous reset, active low
//  cycle_cnt    in   4       free-running phase counter, shared with consumer
//  ex_valid     in   1       execute-stage instruction valid (qualifies all ex_* events)
//  ex_jal       in   1       direct jump resolved
//  ex_jalr      in   1       indirect jump resolved
//  ex_branch    in   1       conditional branch resolved
//  ex_br_taken  in   1       branch outcome (used only with ex_branch)
//  ex_target    in   ADDR_W  jump/branch target
//  trap_req     in   1       exception/trap request (qualified by ex_valid)
//  trap_vec     in   ADDR_W  trap handler address
//  flush        out  2       0=FLUSH_DISABLE, 1=FLUSH_CYCLE_1, 2=FLUSH_CYCLE_2 (3 never driven)
//  flush_pc     out  ADDR_W  redirect address, valid while flush != 0
//  ev_accept    out  1       pulse: event captured this cycle
//  shadow       out  1       high while events are being discarded (PEND or SHADOW)
// BEHAVIOUR
//  Reset (hrstn low at posedge): state=IDLE, flush=0, flush_pc=0, ev_accept=0, shadow cnt=0.
//   Mid-operation reset drops any pending/shadow state; no flush issued afterwards.
//  Event decode (only when ex_valid; priority trap > jalr > taken branch > jal):
//   trap -> code 2, pc=trap_vec; jalr -> 2, ex_target; branch&taken -> 2, ex_target;
//   jal -> 1, ex_target; not-taken branch or no event -> nothing.
//  FSM (registered state):
//   IDLE:   event -> capture code/pc, ev_accept=1, -> PEND (same-cycle multi-event: priority winner).
//   PEND:   first capture wins; later events ignored. At edge with cycle_cnt==SAMPLE_CNT-1,
//           flush<=code, flush_pc<=pc, shadow cnt<=code, -> SHADOW.
//           Event captured in IDLE during cycle SAMPLE_CNT-1 goes straight to output at that edge.
//   SHADOW: flush cleared at edge where cycle_cnt==SAMPLE_CNT (one-cycle presentation).
//           Each edge with cycle_cnt==SAMPLE_CNT decrements shadow cnt; at 0 -> IDLE.
//           All events ignored (ev_accept stays 0), trap included.
//  Latency: event to flush visible = cycles until next cycle_cnt==SAMPLE_CNT (min 1).
//  flush_pc holds its last value when flush==0 (no reset to 0 after issue).
//  cycle_cnt wrap is tolerated; only equality compares used.
//  Outputs all registered; no combinational path input->flush.
// STRUCTURE
//  Shared package: FLUSH_DISABLE/FLUSH_CYCLE_1/FLUSH_CYCLE_2 codes, SAMPLE_CNT default,
//   FSM state encoding (IDLE/PEND/SHADOW) -- same codes as the flush-stall consumer.
//  Sub-module ex_flush_prio: combinational event priority encoder -> {hit, code[1:0], pc}.
//  Top: FSM, capture regs, 2-bit shadow counter, output regs.
// TESTING
//  1 jal @cycle_cnt=1, target 0x100 -> flush=1, flush_pc=0x100 only in cycle_cnt=4 cycle; IDLE after next 4.
//  2 taken branch @cycle_cnt=3, target 0x200 -> flush=2 in immediately following cycle_cnt=4;
//    shadow high through two cnt=4 edges.
//  3 trap+jalr same cycle, trap_vec=0x80 -> code 2, flush_pc=0x80, single ev_accept.
//  4 jal then jalr 1 cycle later (PEND) -> only jal issued (code 1); jalr dropped.
//  5 not-taken branch and ex_valid=0 with jal -> flush stays 0, ev_accept 0.
//  6 hrstn low while in SHADOW with code 2 -> flush=0, shadow=0, next jal accepted normally.

Source files
------------

// File: rtl/ex_flush_gen_pkg.sv
// rtl/ex_flush_gen_pkg.sv - shared flush codes, FSM states and defaults for the execute flush source
package ex_flush_gen_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int SAMPLE_CNT_DEF = 4;

  // Codes are shared with the flush-stall consumer; value 3 is never driven.
  typedef enum logic [1:0] {
    FLUSH_DISABLE = 2'd0,
    FLUSH_CYCLE_1 = 2'd1,
    FLUSH_CYCLE_2 = 2'd2
  } flush_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SHADOW = 2'd2
  } state_t;

endpackage

// File: rtl/ex_flush_gen_if.sv
// rtl/ex_flush_gen_if.sv - execute event inputs and flush/redirect outputs of the flush source
import ex_flush_gen_pkg::*;

interface ex_flush_gen_if #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              ex_valid;
  logic              ex_jal;
  logic              ex_jalr;
  logic              ex_branch;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              trap_req;
  logic [ADDR_W-1:0] trap_vec;
  flush_t            flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              ev_accept;
  logic              shadow;

  modport master (
    output ex_valid, ex_jal, ex_jalr, ex_branch, ex_br_taken, ex_target, trap_req, trap_vec,
    input  flush, flush_pc, ev_accept, shadow
  );

  modport slave (
    input  ex_valid, ex_jal, ex_jalr, ex_branch, ex_br_taken, ex_target, trap_req, trap_vec,
    output flush, flush_pc, ev_accept, shadow
  );
endinterface

// File: rtl/ex_flush_prio.sv
// rtl/ex_flush_prio.sv - combinational priority encoder for resolved execute-stage control-flow events
import ex_flush_gen_pkg::*;

module ex_flush_prio #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              valid,
  input  logic              jal,
  input  logic              jalr,
  input  logic              branch,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] target,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vec,
  output logic              hit,
  output flush_t            code,
  output logic [ADDR_W-1:0] pc
);

  // trap > jalr > taken branch > jal; a not-taken branch is not an event
  always_comb begin
    hit  = 1'b0;
    code = FLUSH_DISABLE;
    pc   = target;
    if (valid) begin
      if (trap_req) begin
        hit  = 1'b1;
        code = FLUSH_CYCLE_2;
        pc   = trap_vec;
      end else if (jalr) begin
        hit  = 1'b1;
        code = FLUSH_CYCLE_2;
      end else if (branch && br_taken) begin
        hit  = 1'b1;
        code = FLUSH_CYCLE_2;
      end else if (jal) begin
        hit  = 1'b1;
        code = FLUSH_CYCLE_1;
      end
    end
  end

endmodule

// File: rtl/ex_flush_gen.sv
// rtl/ex_flush_gen.sv - execute-stage flush source: captures one event, presents it in the sample cycle, then drops shadow events
import ex_flush_gen_pkg::*;

module ex_flush_gen #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SAMPLE_CNT = SAMPLE_CNT_DEF
) (
  input  logic           hclk,
  input  logic           hrstn,
  input  logic [3:0]     cycle_cnt,
  ex_flush_gen_if.slave  bus
);

  localparam logic [3:0] SAMPLE_AT = 4'(SAMPLE_CNT);
  localparam logic [3:0] LOAD_AT   = 4'(SAMPLE_CNT - 1);

  logic              hit;
  flush_t            p_code;
  logic [ADDR_W-1:0] p_pc;

  state_t            state;
  flush_t            code_q;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        shadow_cnt;
  flush_t            flush_q;
  logic [ADDR_W-1:0] flush_pc_q;
  logic              ev_accept_q;
  logic              shadow_q;

  ex_flush_prio #(.ADDR_W(ADDR_W)) u_prio (
    .valid    (bus.ex_valid),
    .jal      (bus.ex_jal),
    .jalr     (bus.ex_jalr),
    .branch   (bus.ex_branch),
    .br_taken (bus.ex_br_taken),
    .target   (bus.ex_target),
    .trap_req (bus.trap_req),
    .trap_vec (bus.trap_vec),
    .hit      (hit),
    .code     (p_code),
    .pc       (p_pc)
  );

  always_ff @(posedge hclk) begin
    if (!hrstn) begin
      state       <= IDLE;
      code_q      <= FLUSH_DISABLE;
      pc_q        <= '0;
      shadow_cnt  <= 2'd0;
      flush_q     <= FLUSH_DISABLE;
      flush_pc_q  <= '0;
      ev_accept_q <= 1'b0;
      shadow_q    <= 1'b0;
    end else begin
      ev_accept_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            ev_accept_q <= 1'b1;
            code_q      <= p_code;
            pc_q        <= p_pc;
            shadow_q    <= 1'b1;
            // An event arriving on the load edge bypasses PEND so it still meets this sample slot.
            if (cycle_cnt == LOAD_AT) begin
              flush_q    <= p_code;
              flush_pc_q <= p_pc;
              shadow_cnt <= p_code;
              state      <= SHADOW;
            end else begin
              state      <= PEND;
            end
          end
        end
        PEND: begin
          if (cycle_cnt == LOAD_AT) begin
            flush_q    <= code_q;
            flush_pc_q <= pc_q;
            shadow_cnt <= code_q;
            state      <= SHADOW;
          end
        end
        SHADOW: begin
          // The flush code doubles as the number of sample slots to stay squashed.
          if (cycle_cnt == SAMPLE_AT) begin
            flush_q    <= FLUSH_DISABLE;
            shadow_cnt <= shadow_cnt - 2'd1;
            if (shadow_cnt <= 2'd1) begin
              state    <= IDLE;
              shadow_q <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          shadow_q <= 1'b0;
          flush_q  <= FLUSH_DISABLE;
        end
      endcase
    end
  end

  assign bus.flush     = flush_q;
  assign bus.flush_pc  = flush_pc_q;
  assign bus.ev_accept = ev_accept_q;
  assign bus.shadow    = shadow_q;

endmodule
